serial_divider: RTL

Multicycle radix-2 restoring divider for the M-extension DIV/DIVU/REM/REMU operations. It sits beside the single-cycle ALU in the execute stage. It takes the same operand_a/operand_b values and produces a result that the execute-stage result mux selects in place of the ALU output. The control unit stalls the pipeline while busy is high.

---
 rtl/serial_divider.sv | 84 ++++++++
 1 files changed

// File: rtl/serial_divider.sv
// serial_divider: radix-2 restoring DIV/DIVU/REM/REMU; DIVIDER_EARLY_OUT_EN enables the |a|<|b| shortcut
module serial_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       div_function,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] quo, rem, divisor, result_q, a_mag, b_mag, fixed;
    logic [CW-1:0] count;
    logic [WIDTH:0] diff;
    logic is_rem, q_neg, r_neg, signed_op, a_neg, b_neg, div_zero, overflow, early, quick, accept;
    assign signed_op = ~div_function[0];
    assign a_neg = signed_op & operand_a[WIDTH-1];
    assign b_neg = signed_op & operand_b[WIDTH-1];
    assign a_mag = a_neg ? -operand_a : operand_a;
    assign b_mag = b_neg ? -operand_b : operand_b;
    assign div_zero = operand_b == '0;
    assign overflow = signed_op && operand_a == {1'b1, {(WIDTH-1){1'b0}}} && &operand_b;
`ifdef DIVIDER_EARLY_OUT_EN
    assign early = ~div_zero & (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif
    assign quick = div_zero | overflow | early;
    assign accept = start & ~kill;
    // {rem, next dividend bit} never exceeds WIDTH+1 bits since rem < divisor
    assign diff = {rem, quo[WIDTH-1]} - {1'b0, divisor};
    assign fixed = is_rem ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = accept ? (quick ? DONE : CALC) : IDLE;
            CALC: state_next = kill ? IDLE : (count == '0 ? DONE : CALC);
            default: state_next = IDLE;
        endcase
    end
    always_comb begin
        busy = state != IDLE;
        done = state == DONE && !kill;
        result = done ? fixed : result_q;
    end
    // Special cases preload quo/rem so DONE only has to apply the sign fixup
    always_ff @(posedge clock) begin
        if (!reset) begin
            quo <= '0;
            rem <= '0;
            divisor <= '0;
            result_q <= '0;
            count <= '0;
            is_rem <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && accept) begin
            is_rem <= div_function[1];
            divisor <= b_mag;
            count <= CW'(WIDTH - 1);
            q_neg <= (a_neg ^ b_neg) & ~div_zero & ~overflow;
            r_neg <= a_neg & ~div_zero & ~overflow;
            quo <= div_zero ? '1 : overflow ? operand_a : early ? '0 : a_mag;
            rem <= div_zero ? operand_a : early ? a_mag : '0;
        end else if (state == CALC) begin
            count <= count - 1'b1;
            rem <= diff[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        end else if (done) begin
            result_q <= fixed;
        end
    end
endmodule
